// File: rtl/stock_window_packer.sv
// Three-day price window packer with ownership tracking and valid/ready handshakes.
// Optional STOCK_WINDOW_PRIME_EN: the first sample after reset fills the whole window.
module stock_window_packer #(
    parameter int PRICE_W   = 5,
    parameter int PRICE_MAX = 31
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               price_valid,
    input  logic [7:0]         price_in,
    output logic               price_ready,
    output logic [3*PRICE_W:0] stock_out,
    output logic               stock_valid,
    input  logic               stock_ready,
    input  logic [15:0]        action_in,
    output logic               own_out,
    output logic [1:0]         days_seen,
    output logic               err_out
);

    typedef enum logic [1:0] {
        FILL,
        IDLE,
        EMIT
    } state_t;

    localparam logic [7:0]         MAX_IN   = 8'(PRICE_MAX);
    localparam logic [PRICE_W-1:0] MAX_SLOT = PRICE_W'(PRICE_MAX);

    state_t             state;
    state_t             state_nxt;
    logic [PRICE_W-1:0] oldest;
    logic [PRICE_W-1:0] middle;
    logic [PRICE_W-1:0] newest;
    logic [PRICE_W-1:0] sat;
    logic [PRICE_W-1:0] oldest_nxt;
    logic [PRICE_W-1:0] middle_nxt;
    logic [1:0]         days;
    logic [1:0]         days_nxt;
    logic               own;
    logic               own_nxt;
    logic               err;
    logic               err_nxt;
    logic               accept;
    logic               handshake;
    logic               prime;

    assign price_ready = (state != EMIT);
    assign stock_valid = (state == EMIT);
    assign own_out     = own;
    assign days_seen   = days;
    assign err_out     = err;

    assign accept    = price_valid && price_ready;
    assign handshake = stock_valid && stock_ready;

    assign sat = (price_in > MAX_IN) ? MAX_SLOT
                                     : price_in[PRICE_W-1:0];

`ifdef STOCK_WINDOW_PRIME_EN
    assign prime = (days == 2'd0);
`else
    assign prime = 1'b0;
`endif

    assign oldest_nxt = prime ? sat : middle;
    assign middle_nxt = prime ? sat : newest;

    // Window occupancy after an accept, saturating at a full window
    always_comb begin
        days_nxt = days;
        if (prime || days == 2'd3) begin
            days_nxt = 2'd3;
        end else begin
            days_nxt = days + 2'd1;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= FILL;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state: emit once the window is full
    always_comb begin
        state_nxt = state;
        case (state)
            FILL: begin
                if (accept && days_nxt == 2'd3) begin
                    state_nxt = EMIT;
                end
            end
            IDLE: begin
                if (accept) begin
                    state_nxt = EMIT;
                end
            end
            EMIT: begin
                if (handshake) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = FILL;
        endcase
    end

    // Window shift and output word capture on each accepted sample
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            oldest    <= '0;
            middle    <= '0;
            newest    <= '0;
            days      <= 2'd0;
            stock_out <= '0;
        end else if (accept) begin
            oldest <= oldest_nxt;
            middle <= middle_nxt;
            newest <= sat;
            days   <= days_nxt;
            if (state_nxt == EMIT) begin
                stock_out <= {own, oldest_nxt, middle_nxt, sat};
            end
        end
    end

    // Decode the returned action into ownership and the sticky error flag
    always_comb begin
        own_nxt = own;
        err_nxt = err;
        if (handshake) begin
            case (action_in)
                16'd1, 16'd2:        own_nxt = 1'b0;
                16'd3, 16'd4, 16'd7: own_nxt = 1'b1;
                16'd8:               own_nxt = own;
                default:             err_nxt = 1'b1;
            endcase
        end
    end

    // Ownership and error registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            own <= 1'b0;
            err <= 1'b0;
        end else begin
            own <= own_nxt;
            err <= err_nxt;
        end
    end

endmodule

// File: tb/tb_stock_window_packer.sv
// Randomized scoreboard bench for stock_window_packer.
// Reference model keeps accepted prices in a queue and applies action rules directly.
module tb_stock_window_packer;

    logic        clk;
    logic        rst;
    logic        price_valid;
    logic [7:0]  price_in;
    logic        price_ready;
    logic [15:0] stock_out;
    logic        stock_valid;
    logic        stock_ready;
    logic [15:0] action_in;
    logic        own_out;
    logic [1:0]  days_seen;
    logic        err_out;

    int n_vec;
    int n_err;

    logic [4:0]  hist[$];
    logic [15:0] exp_q[$];
    logic        m_own;
    logic        m_err;
    logic        pending;

    stock_window_packer dut (
        .clk        (clk),
        .rst        (rst),
        .price_valid(price_valid),
        .price_in   (price_in),
        .price_ready(price_ready),
        .stock_out  (stock_out),
        .stock_valid(stock_valid),
        .stock_ready(stock_ready),
        .action_in  (action_in),
        .own_out    (own_out),
        .days_seen  (days_seen),
        .err_out    (err_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic logic [4:0] sat5(input logic [7:0] p);
        return (p > 8'd31) ? 5'd31 : p[4:0];
    endfunction

    // Monitor and reference model, evaluated between clock edges
    always @(negedge clk) begin
        if (!rst) begin
            hist.delete();
            exp_q.delete();
            m_own   = 1'b0;
            m_err   = 1'b0;
            pending = 1'b0;
            check("rst_stock_out", stock_out, 0);
            check("rst_stock_valid", stock_valid, 0);
            check("rst_price_ready", price_ready, 1);
            check("rst_own", own_out, 0);
            check("rst_days", days_seen, 0);
            check("rst_err", err_out, 0);
        end else begin
            check("price_ready", price_ready, !pending);
            check("stock_valid", stock_valid, pending);
            check("own_out", own_out, m_own);
            check("err_out", err_out, m_err);
            check("days_seen", days_seen, hist.size());
            if (stock_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", stock_out, 32'hdead_beef);
                end else begin
                    check("stock_out", stock_out, exp_q[0]);
                end
            end
            if (pending && stock_ready) begin
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                pending = 1'b0;
                case (action_in)
                    16'd1, 16'd2:        m_own = 1'b0;
                    16'd3, 16'd4, 16'd7: m_own = 1'b1;
                    16'd8:               ;
                    default:             m_err = 1'b1;
                endcase
            end else if (price_valid && !pending) begin
`ifdef STOCK_WINDOW_PRIME_EN
                if (hist.size() == 0) begin
                    hist.push_back(sat5(price_in));
                    hist.push_back(sat5(price_in));
                end
`endif
                hist.push_back(sat5(price_in));
                while (hist.size() > 3) void'(hist.pop_front());
                if (hist.size() == 3) begin
                    exp_q.push_back({m_own, hist[0], hist[1], hist[2]});
                    pending = 1'b1;
                end
            end
        end
    end

    task automatic send_price(input logic [7:0] p);
        price_valid = 1'b1;
        price_in    = p;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (price_ready) begin
                @(posedge clk);
                #1;
                price_valid = 1'b0;
                return;
            end
        end
        price_valid = 1'b0;
        check("send_timeout", 0, 1);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [15:0] codes[6];

    initial begin
        n_vec       = 0;
        n_err       = 0;
        rst         = 1'b0;
        price_valid = 1'b0;
        price_in    = 8'd0;
        stock_ready = 1'b1;
        action_in   = 16'd8;
        codes       = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd7, 16'd8};
        repeat (3) step();
        rst = 1'b1;
        step();

        action_in = 16'd7;
        send_price(8'd10);
`ifndef STOCK_WINDOW_PRIME_EN
        send_price(8'd10);
        send_price(8'd10);
        check("first_word", stock_out, 16'h294A);
        step();
        action_in = 16'd1;
        send_price(8'd12);
        check("own_word", stock_out, 16'hA94C);
        step();
        action_in = 16'd8;
        send_price(8'd200);
        check("sat_word", stock_out, 16'h299F);
`else
        check("prime_word", stock_out, 16'h294A);
        step();
        action_in = 16'd1;
        send_price(8'd12);
        check("own_word", stock_out, 16'hA94C);
        step();
        action_in = 16'd8;
        send_price(8'd200);
        check("sat_word", stock_out, 16'h299F);
`endif
        stock_ready = 1'b0;
        price_valid = 1'b1;
        price_in    = 8'd20;
        repeat (5) step();
        check("bp_stock_out", stock_out, 16'h299F);
        check("bp_price_ready", price_ready, 0);
        price_valid = 1'b0;
        action_in   = 16'd3;
        stock_ready = 1'b1;
        step();
        action_in = 16'd5;
        send_price(8'd20);
        check("after_bp_word", stock_out, 16'hB3F4);
        step();
        check("err_set", err_out, 1);
        check("own_kept", own_out, 1);
        action_in = 16'd4;
        send_price(8'd3);
        step();
        check("err_sticky", err_out, 1);

        for (int i = 0; i < 2000; i++) begin
            price_valid = ($urandom_range(0, 3) != 0);
            price_in    = 8'($urandom_range(0, 255));
            stock_ready = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 49) == 0) begin
                action_in = 16'($urandom_range(0, 15));
            end else begin
                action_in = codes[$urandom_range(0, 5)];
            end
            if (i == 1000) begin
                rst = 1'b0;
                step();
                rst = 1'b1;
            end
            step();
        end

        price_valid = 1'b1;
        price_in    = 8'd50;
        stock_ready = 1'b0;
        for (int i = 0; i < 50 && !stock_valid; i++) step();
        check("emit_before_rst", stock_valid, 1);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_stock_out", stock_out, 0);
        check("mid_rst_valid", stock_valid, 0);
        check("mid_rst_ready", price_ready, 1);
        check("mid_rst_own", own_out, 0);
        check("mid_rst_days", days_seen, 0);
        check("mid_rst_err", err_out, 0);
        price_valid = 1'b0;
        step();
        rst         = 1'b1;
        stock_ready = 1'b1;
        action_in   = 16'd8;
        step();
        send_price(8'd9);
`ifndef STOCK_WINDOW_PRIME_EN
        send_price(8'd9);
        send_price(8'd9);
`endif
        check("post_rst_word", stock_out, 16'h2529);
        repeat (4) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/stock_window_packer.md
# stock_window_packer

- Producer side of the day-trading decision interface.
- Accepts one daily price sample per handshake and keeps a three-day sliding window.
- Tracks stock ownership from the decision codes returned by the `day_trading` block.
- Emits the packed 16-bit `stock_in` word {own, oldest, middle, newest} with a valid/ready handshake.

## Interface
- `PRICE_W`, 5: width of each packed price slot; the word width is 1+3*PRICE_W = 16.
- `PRICE_MAX`, 31: saturation ceiling applied to incoming prices.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-low reset; clears all state immediately.
- `price_valid` in 1: `price_in` is valid.
- `price_in` in 8: raw daily price, unsigned.
- `price_ready` out 1: block accepts a price this cycle.
- `stock_out` out 16: packed word, [15]=own, [14:10]=oldest, [9:5]=middle, [4:0]=newest.
- `stock_valid` out 1: `stock_out` is valid.
- `stock_ready` in 1: consumer takes `stock_out` this cycle.
- `action_in` in 16: decision code from `day_trading`, valid while `stock_valid` is high.
- `own_out` out 1: current ownership flag.
- `days_seen` out 2: number of samples in the window, saturating at 3.
- `err_out` out 1: sticky flag, set when an unrecognised action code is received.

## Operation
- States:
  - FILL: fewer than 3 samples held.
  - IDLE: window full, waiting for a price.
  - EMIT: word presented to the consumer.
- On price accept (`price_valid && price_ready`):
  - The window shifts: oldest<=middle, middle<=newest, newest<=min(price_in, PRICE_MAX).
  - `days_seen` increments, saturating at 3.
- `price_ready` = 1 in FILL and IDLE, 0 in EMIT.
- Transitions:
  - FILL -> EMIT on the accept that brings `days_seen` to 3; otherwise stay in FILL.
  - IDLE -> EMIT on accept.
  - EMIT -> IDLE on `stock_valid && stock_ready`.
- `stock_out` is registered on entry to EMIT from the shifted window and the current `own`. It holds stable until the handshake and keeps its last value after the handshake.
- `action_in` is sampled in the handshake cycle. `own` updates on the following edge:
  - 1 (sell all) -> 0.
  - 2 (stay out) -> 0.
  - 3 (buy more) -> 1.
  - 4 (buy a lot) -> 1.
  - 7 (buy a little) -> 1.
  - 8 (hold) -> own unchanged.
  - Any other code -> own unchanged and `err_out` set.
- `err_out` clears only on reset.
- `price_valid` while in EMIT is ignored; no sample is lost or captured.

## Timing
- Reset values:
  - `stock_out`=0, `stock_valid`=0, `price_ready`=1, `own_out`=0, `days_seen`=0, `err_out`=0.
  - State = FILL, all window slots = 0.
- Latency: price accepted at edge N -> `stock_valid`=1 from N+1.
- Throughput: `price_ready` returns high the cycle after the stock handshake. Minimum spacing is one word per 2 cycles.
- Backpressure: with `stock_ready`=0, `stock_out`, `stock_valid` and `price_ready`=0 hold indefinitely.
- `own_out` reflects a new action one cycle after the handshake. The next word packs the updated `own`.
- Reset asserted mid-EMIT: outputs return to reset values asynchronously. The first edge after release sees FILL.
- Saturation: any `price_in` > PRICE_MAX packs as PRICE_MAX (31).

## Configuration
- `STOCK_WINDOW_PRIME_EN`, defined:
  - The first sample accepted after reset is written into all three slots.
  - `days_seen` goes to 3 and the block moves FILL -> EMIT immediately.
- `STOCK_WINDOW_PRIME_EN`, undefined:
  - Three distinct samples are required before the first word is emitted.

## Test plan
- Reset, then feed 10, 10, 10 with `stock_ready`=1 -> a single word 0x294A one cycle after the third accept. Return `action_in`=7 -> `own_out`=1 next cycle.
- Continue the previous scenario with price 12 -> `stock_out`=0xA94C (own=1, window 10,10,12). Return `action_in`=1 -> `own_out`=0.
- Feed price 200 into a full window -> newest slot = 31, e.g. window 12,12,200 packs 0x319F with own=0.
- Hold `stock_ready`=0 for 5 cycles while driving `price_valid`=1 with 20:
  - `stock_out` stays stable and `price_ready`=0.
  - Window unchanged after release.
  - Handshake completes on the first `stock_ready`=1.
- Return `action_in`=5 with own=1 -> `own_out` stays 1 and `err_out`=1. `err_out` stays 1 through later valid codes until `rst`=0.
- Assert `rst`=0 mid-EMIT -> all outputs zero immediately, `price_ready`=1. With `STOCK_WINDOW_PRIME_EN`, a first sample of 9 after release -> `stock_out`=0x2529 one cycle later.
